// File: rtl/irq_ctrl.sv
// Interrupt controller: rising-edge capture into pending bits, masking, fixed
// lowest-index priority and an IDLE/ASSERT/SERVICE handshake with the CPU.
module irq_ctrl #(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned CW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  src,
  output logic              irq,
  output logic [CW-1:0]     cause,
  input  logic              ack,
  input  logic              rfe,
  input  logic              reg_we,
  input  logic [1:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t            state;
  logic [N_SRC-1:0]  prevSrc;
  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  mask;
  logic              gie;

  logic [N_SRC-1:0]  edges;
  logic [N_SRC-1:0]  w1cClr;
  logic [N_SRC-1:0]  ackClr;
  logic [N_SRC-1:0]  pendingNext;
  logic [N_SRC-1:0]  eligible;
  logic [CW-1:0]     winIdx;
  logic              anyEligible;
  logic              unusedOk;

  // Only the low N_SRC bits (and bit0 for CTRL) of write data are meaningful.
  assign unusedOk = ^reg_wdata;

  // Pending update: clears first, then edges OR'd in so a coincident set wins.
  always_comb begin
    edges       = src & ~prevSrc;
    w1cClr      = '0;
    ackClr      = '0;
    if (reg_we && reg_addr == 2'd0) begin
      w1cClr = reg_wdata[N_SRC-1:0];
    end
    if (state == ASSERT && ack) begin
      ackClr = N_SRC'(1) << cause;
    end
    pendingNext = (pending & ~(w1cClr | ackClr)) | edges;
  end

  // Lowest eligible index wins; scanning downward leaves the lowest hit last.
  always_comb begin
    eligible    = pending & mask;
    anyEligible = |eligible;
    winIdx      = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winIdx = CW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      irq     <= 1'b0;
      cause   <= '0;
      prevSrc <= '1;
      pending <= '0;
      mask    <= '0;
      gie     <= 1'b0;
    end else begin
      prevSrc <= src;
      pending <= pendingNext;
      if (reg_we && reg_addr == 2'd1) begin
        mask <= reg_wdata[N_SRC-1:0];
      end
      if (reg_we && reg_addr == 2'd2) begin
        gie <= reg_wdata[0];
      end
      case (state)
        IDLE: begin
          if (gie && anyEligible) begin
            state <= ASSERT;
            cause <= winIdx;
            irq   <= 1'b1;
          end
        end
        ASSERT: begin
          if (ack) begin
            state <= SERVICE;
            irq   <= 1'b0;
          end
        end
        SERVICE: begin
          if (rfe) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  // Register read window.
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      2'd0: reg_rdata[N_SRC-1:0] = pending;
      2'd1: reg_rdata[N_SRC-1:0] = mask;
      2'd2: reg_rdata[0]         = gie;
      default: begin
        reg_rdata[CW-1:0] = cause;
        reg_rdata[9:8]    = state;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: hand-computed expectations checked with
// immediate assertions, sampling on the falling edge.
module tb_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  src;
  logic        irq;
  logic [2:0]  cause;
  logic        ack;
  logic        rfe;
  logic        regWe;
  logic [1:0]  regAddr;
  logic [31:0] regWdata;
  logic [31:0] regRdata;

  int checks;
  int failures;

  irq_ctrl #(.N_SRC(8), .CW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .src       (src),
    .irq       (irq),
    .cause     (cause),
    .ack       (ack),
    .rfe       (rfe),
    .reg_we    (regWe),
    .reg_addr  (regAddr),
    .reg_wdata (regWdata),
    .reg_rdata (regRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic readChk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    regAddr = addr;
    #1;
    chk(tag, regRdata, exp);
  endtask

  task automatic chkIrq(input string tag, input logic expIrq, input logic [2:0] expCause);
    chk({tag, "_irq"}, 32'(irq), 32'(expIrq));
    chk({tag, "_cause"}, 32'(cause), 32'(expCause));
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
    regWe    = 1'b1;
    regAddr  = addr;
    regWdata = data;
    tick();
    regWe    = 1'b0;
    regWdata = '0;
  endtask

  task automatic pulseAck();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic pulseRfe();
    rfe = 1'b1;
    tick();
    rfe = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    src      = '0;
    ack      = 1'b0;
    rfe      = 1'b0;
    regWe    = 1'b0;
    regAddr  = '0;
    regWdata = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chkIrq("rst", 1'b0, 3'd0);
    readChk("rst_pend", 2'd0, 32'h0);
    readChk("rst_mask", 2'd1, 32'h0);
    readChk("rst_ctrl", 2'd2, 32'h0);
    readChk("rst_stat", 2'd3, 32'h0);

    // Basic: src[3] pulse, 2-cycle latency, ack, rfe
    writeReg(2'd1, 32'hFF);
    writeReg(2'd2, 32'h1);
    readChk("mask_rd", 2'd1, 32'hFF);
    readChk("ctrl_rd", 2'd2, 32'h1);
    src = 8'h08;
    tick();
    src = 8'h00;
    chkIrq("basic_lat1", 1'b0, 3'd0);
    readChk("basic_pend", 2'd0, 32'h08);
    tick();
    chkIrq("basic_lat2", 1'b1, 3'd3);
    readChk("basic_stat_assert", 2'd3, 32'h103);
    pulseAck();
    chkIrq("basic_ack", 1'b0, 3'd3);
    readChk("basic_pend_ack", 2'd0, 32'h00);
    readChk("basic_stat_svc", 2'd3, 32'h203);
    pulseRfe();
    readChk("basic_stat_idle", 2'd3, 32'h003);

    // Priority: src[5] and src[2] together
    src = 8'h24;
    tick();
    src = 8'h00;
    tick();
    chkIrq("prio_first", 1'b1, 3'd2);
    pulseAck();
    readChk("prio_pend", 2'd0, 32'h20);
    pulseRfe();
    chk("prio_rfe_irq", 32'(irq), 32'd0);
    tick();
    chkIrq("prio_second", 1'b1, 3'd5);
    pulseAck();
    pulseRfe();
    readChk("prio_pend_end", 2'd0, 32'h00);

    // Masking: pending recorded while masked, enabling presents it
    writeReg(2'd1, 32'h00);
    src = 8'h02;
    tick();
    src = 8'h00;
    tick();
    readChk("mask_pend", 2'd0, 32'h02);
    chk("mask_irq_low", 32'(irq), 32'd0);
    writeReg(2'd1, 32'h02);
    chk("mask_write_edge", 32'(irq), 32'd0);
    tick();
    chkIrq("mask_enable", 1'b1, 3'd1);
    pulseAck();
    pulseRfe();
    writeReg(2'd1, 32'hFF);

    // Collision: W1C vs edge on bit4 (GIE off so the FSM stays idle)
    writeReg(2'd2, 32'h0);
    src = 8'h10;
    tick();
    src = 8'h00;
    tick();
    readChk("coll_pend_pre", 2'd0, 32'h10);
    src = 8'h10;
    writeReg(2'd0, 32'h10);
    src = 8'h00;
    readChk("coll_w1c_edge", 2'd0, 32'h10);
    writeReg(2'd0, 32'h10);
    readChk("coll_w1c_clear", 2'd0, 32'h00);

    // Collision: src[0] edge coincident with ack of cause 0
    writeReg(2'd2, 32'h1);
    src = 8'h01;
    tick();
    src = 8'h00;
    tick();
    chkIrq("coll_ack_pre", 1'b1, 3'd0);
    src = 8'h01;
    pulseAck();
    src = 8'h00;
    chk("coll_ack_irq", 32'(irq), 32'd0);
    readChk("coll_ack_pend", 2'd0, 32'h01);
    readChk("coll_ack_stat", 2'd3, 32'h200);
    pulseRfe();
    tick();
    chkIrq("coll_ack_again", 1'b1, 3'd0);
    pulseAck();
    pulseRfe();
    readChk("coll_pend_end", 2'd0, 32'h00);

    // Protocol misuse
    pulseAck();
    readChk("misuse_ack_idle", 2'd3, 32'h000);
    chk("misuse_ack_idle_irq", 32'(irq), 32'd0);
    src = 8'h40;
    tick();
    src = 8'h00;
    tick();
    chkIrq("misuse_assert", 1'b1, 3'd6);
    pulseRfe();
    chkIrq("misuse_rfe_assert", 1'b1, 3'd6);
    readChk("misuse_rfe_stat", 2'd3, 32'h106);
    pulseAck();
    src = 8'h80;
    tick();
    src = 8'h00;
    readChk("misuse_svc_pend", 2'd0, 32'h80);
    tick();
    chk("misuse_svc_irq", 32'(irq), 32'd0);
    readChk("misuse_svc_stat", 2'd3, 32'h206);
    pulseRfe();
    chk("misuse_rfe_irq", 32'(irq), 32'd0);
    tick();
    chkIrq("misuse_next", 1'b1, 3'd7);

    // Reset mid-request with src[0] held high through reset
    src = 8'h01;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkIrq("midrst", 1'b0, 3'd0);
    readChk("midrst_pend", 2'd0, 32'h00);
    readChk("midrst_mask", 2'd1, 32'h00);
    readChk("midrst_stat", 2'd3, 32'h000);
    writeReg(2'd1, 32'hFF);
    writeReg(2'd2, 32'h1);
    tick();
    tick();
    chk("held_no_irq", 32'(irq), 32'd0);
    readChk("held_no_pend", 2'd0, 32'h00);
    src = 8'h00;
    tick();
    src = 8'h01;
    tick();
    readChk("rearm_pend", 2'd0, 32'h01);
    tick();
    chkIrq("rearm_irq", 1'b1, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller that drives the CPU's single external `irq` line. It collects up to `N_SRC` peripheral request lines, detects rising edges into per-source pending bits, and applies a per-source mask and a global enable. It presents the highest-priority pending source to the CPU and holds it there until the CPU acknowledges exception entry and later signals return-from-exception (RFE). It sits between the peripherals and the `cpu` top, and also exposes a small register window for software control.

## Interface
Parameters:
- `N_SRC`, 8: number of request lines, 1..32.
- `CW`, 3: cause width, = clog2(`N_SRC`), minimum 1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `src`  in  `N_SRC`  request lines, synchronous to `clk`; a rising edge raises a request.
- `irq`  out  1  interrupt request to the CPU; registered.
- `cause`  out  `CW`  index of the source being presented/serviced; registered.
- `ack`  in  1  one-cycle pulse from the CPU on exception entry.
- `rfe`  in  1  one-cycle pulse from the CPU when RFE retires.
- `reg_we`  in  1  register write strobe.
- `reg_addr`  in  2  register select.
- `reg_wdata`  in  32  write data.
- `reg_rdata`  out  32  read data; combinational from `reg_addr`.

## Operation
Registers:
- 0 PEND: read gives pending[N-1:0]. A write clears every bit written as 1 (W1C).
- 1 MASK: R/W. 1 = source enabled.
- 2 CTRL: bit0 GIE (global enable). Other bits read 0.
- 3 STAT, read-only: [CW-1:0] cause, [9:8] state (IDLE=0, ASSERT=1, SERVICE=2).
- Unused upper bits read 0. Writes to STAT are ignored.

Edge detection:
- `prev` holds last cycle's `src`.
- edge[i] = src[i] & ~prev[i].
- An edge sets pending[i] regardless of MASK and GIE.

Priority:
- eligible = pending & MASK.
- Lowest index wins.

State machine:
- IDLE: if GIE and eligible≠0, go to ASSERT. On that transition, latch `cause` = winning index and drive `irq`=1.
- ASSERT: `irq`=1 and `cause` is frozen.
  - On `ack`: clear pending[cause], go to SERVICE, `irq`=0.
  - Mask, GIE or PEND writes do not withdraw the request.
- SERVICE: `irq`=0; no new request is presented (no nesting).
  - On `rfe`: go to IDLE.
  - `cause` holds its value until the next IDLE→ASSERT transition.
- `ack` outside ASSERT and `rfe` outside SERVICE are ignored.

Collisions and edge cases:
- Simultaneous set and clear of the same pending bit (edge vs W1C, or edge vs ack-clear): set wins, bit stays 1.
- A level held high creates only one edge; re-raising requires the line to go low for at least one cycle.

Reset values:
- `irq`=0, `cause`=0, state=IDLE.
- pending=0, MASK=0, GIE=0.
- `prev`=all 1s, so lines already high at reset do not fire.
- Asserting `rst` in any state returns everything to these values at the next edge. An in-flight request is dropped and the CPU sees `irq` fall.

## Timing
- `src[i]` first sampled high at edge n → pending[i]=1 after edge n → `irq`=1 after edge n+1, provided MASK[i], GIE and IDLE hold. Latency is 2 cycles.
- `ack` sampled at edge m → `irq`=0 and pending[cause] cleared after edge m.
- `rfe` sampled at edge k → IDLE after k. If another source is eligible, `irq`=1 again after edge k+1.
- A register write takes effect after its edge. A read reflects current register state in the same cycle.
- Enabling MASK or GIE while a source is pending → `irq`=1 one cycle after the enabling write.

## Test plan
- Reset: set MASK=0xFF, GIE=1, src[3] pulse → `irq` rises 2 cycles after the pulse, `cause`=3, PEND=0x08. Then `ack` → `irq`=0, PEND=0x00, STAT state=2.
- Priority: src[5] and src[2] rise in the same cycle → `cause`=2. After ack and rfe, `irq` re-asserts one cycle after rfe with `cause`=5.
- Masking: MASK=0x00, GIE=1, src[1] edge → PEND=0x02 and `irq` stays 0. Write MASK=0x02 → `irq`=1 next cycle, `cause`=1.
- Collision: in the same cycle, write PEND=0x10 (W1C) and apply a src[4] edge → PEND bit4 remains 1. Also apply a src[0] edge coincident with `ack` of cause 0 → pending[0] remains 1.
- Protocol misuse: `ack` in IDLE and `rfe` in ASSERT → no state change. A new edge during SERVICE sets pending but `irq` stays 0 until rfe.
- Reset mid-request: `rst` asserted in ASSERT → after the next edge `irq`=0, PEND=0, MASK=0. A `src` held high through reset produces no request.
